// File: rtl/parent_link_router_pkg.sv
// Shared definitions for the parent-side link router.
// Holds the message header field positions, the broadcast destination ID,
// the header layout struct and the downstream FSM state encoding.
package parent_link_router_pkg;

   localparam int unsigned MSG_TYPE_MSB = 63;
   localparam int unsigned MSG_TYPE_LSB = 60;
   localparam int unsigned MSG_DEST_MSB = 59;
   localparam int unsigned MSG_DEST_LSB = 56;
   localparam int unsigned DEST_WIDTH   = 4;

   localparam logic [DEST_WIDTH-1:0] BROADCAST_ID = 4'hF;

   // Header layout of a single-beat 64-bit link message
   typedef struct packed {
      logic [3:0]  msg_type;
      logic [3:0]  dest;
      logic [55:0] payload;
   } msg_t;

   // Downstream delivery FSM
   typedef enum logic {
      DS_IDLE    = 1'b0,
      DS_DELIVER = 1'b1
   } ds_state_t;

endpackage

// File: rtl/parent_link_router_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request at or above ptr, wrapping around.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - highest-priority requester index this cycle (register lives in parent)
//   grant - one-hot grant, all zeros when no request is asserted
module parent_link_router_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = 2
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant
);

   logic             found;
   logic [PTR_W-1:0] idx;

   // Rotating search starting at ptr; first hit wins
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/parent_link_router.sv
// Parent-side end of the parent_rx/parent_tx link.
// Downstream: accepts single-beat messages from the root controller and
// delivers each to one child (dest 1..NUM_CHILDREN) or to all children
// (dest 4'hF); other destinations are dropped and counted.
// Upstream: merges child reports into one registered stream towards the
// root controller through a round-robin arbiter.
// Ports:
//   clk, reset                      - clock, async active-high reset
//   host_down_data/valid/ready      - root controller -> router
//   host_up_data/valid/ready        - router -> root controller
//   child_rx_data/valid/ready       - router -> children (slice i = child ID i+1)
//   child_tx_data/valid/ready       - children -> router
//   drop_count                      - saturating count of undeliverable messages
module parent_link_router
   import parent_link_router_pkg::*;
#(
   parameter int unsigned NUM_CHILDREN   = 4,
   parameter int unsigned MSG_WIDTH      = 64,
   parameter int unsigned DROP_CNT_WIDTH = 16
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic [MSG_WIDTH-1:0]              host_down_data,
   input  logic                              host_down_valid,
   output logic                              host_down_ready,
   output logic [MSG_WIDTH-1:0]              host_up_data,
   output logic                              host_up_valid,
   input  logic                              host_up_ready,
   output logic [MSG_WIDTH*NUM_CHILDREN-1:0] child_rx_data,
   output logic [NUM_CHILDREN-1:0]           child_rx_valid,
   input  logic [NUM_CHILDREN-1:0]           child_rx_ready,
   input  logic [MSG_WIDTH*NUM_CHILDREN-1:0] child_tx_data,
   input  logic [NUM_CHILDREN-1:0]           child_tx_valid,
   output logic [NUM_CHILDREN-1:0]           child_tx_ready,
   output logic [DROP_CNT_WIDTH-1:0]         drop_count
);

   localparam int unsigned PTR_W = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;

   // ------------------------------------------------------------------
   // Downstream path
   // ------------------------------------------------------------------
   ds_state_t               ds_state;
   logic [MSG_WIDTH-1:0]    hold_msg;
   logic [NUM_CHILDREN-1:0] target_mask;
   logic [NUM_CHILDREN-1:0] delivered;

   logic [DEST_WIDTH-1:0]   down_dest_c;
   logic [NUM_CHILDREN-1:0] dest_mask_c;
   logic                    dest_valid_c;
   logic                    down_accept_c;
   logic [NUM_CHILDREN-1:0] delivered_next_c;
   logic                    deliver_done_c;

   assign down_accept_c    = host_down_valid & host_down_ready;
   assign down_dest_c      = host_down_data[MSG_DEST_MSB:MSG_DEST_LSB];
   assign delivered_next_c = delivered | (child_rx_valid & child_rx_ready);
   assign deliver_done_c   = ((delivered_next_c & target_mask) == target_mask);

   // Every child slice carries the held message; valid picks the recipients
   assign child_rx_data = {NUM_CHILDREN{hold_msg}};

   // Destination decode: one-hot for unicast, all ones for broadcast
   always_comb begin
      dest_mask_c  = '0;
      dest_valid_c = 1'b0;
      if (down_dest_c == BROADCAST_ID) begin
         dest_mask_c  = '1;
         dest_valid_c = 1'b1;
      end else begin
         for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
            if (32'(down_dest_c) == i + 1) begin
               dest_mask_c[i] = 1'b1;
               dest_valid_c   = 1'b1;
            end
         end
      end
   end

   // Delivery FSM; child_rx_valid tracks target & ~delivered as a register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ds_state        <= DS_IDLE;
         host_down_ready <= 1'b0;
         hold_msg        <= '0;
         target_mask     <= '0;
         delivered       <= '0;
         child_rx_valid  <= '0;
         drop_count      <= '0;
      end else begin
         case (ds_state)
            DS_IDLE: begin
               host_down_ready <= 1'b1;
               if (down_accept_c) begin
                  if (dest_valid_c) begin
                     hold_msg        <= host_down_data;
                     target_mask     <= dest_mask_c;
                     delivered       <= '0;
                     child_rx_valid  <= dest_mask_c;
                     host_down_ready <= 1'b0;
                     ds_state        <= DS_DELIVER;
                  end else if (drop_count != '1) begin
                     drop_count <= drop_count + DROP_CNT_WIDTH'(1);
                  end
               end
            end
            DS_DELIVER: begin
               if (deliver_done_c) begin
                  delivered       <= '0;
                  child_rx_valid  <= '0;
                  host_down_ready <= 1'b1;
                  ds_state        <= DS_IDLE;
               end else begin
                  delivered      <= delivered_next_c;
                  child_rx_valid <= target_mask & ~delivered_next_c;
               end
            end
            default: ds_state <= DS_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Upstream path
   // ------------------------------------------------------------------
   logic [PTR_W-1:0]        rr_ptr;
   logic [NUM_CHILDREN-1:0] arb_grant_c;
   logic [NUM_CHILDREN-1:0] up_grant_c;
   logic                    up_load_ok_c;
   logic [MSG_WIDTH-1:0]    up_sel_data_c;
   logic [PTR_W-1:0]        up_next_ptr_c;

   // Register can take a new beat when empty or draining this cycle
   assign up_load_ok_c = ~host_up_valid | host_up_ready;

   parent_link_router_rr_arbiter #(
      .NUM_REQ (NUM_CHILDREN),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req   (child_tx_valid),
      .ptr   (rr_ptr),
      .grant (arb_grant_c)
   );

   assign up_grant_c = up_load_ok_c ? arb_grant_c : '0;

   // Ready is the grant itself, held low while reset is asserted
   assign child_tx_ready = reset ? '0 : up_grant_c;

   // Granted child's data and the pointer that follows it
   always_comb begin
      up_sel_data_c = '0;
      up_next_ptr_c = rr_ptr;
      for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
         if (arb_grant_c[i]) begin
            up_sel_data_c = up_sel_data_c | child_tx_data[MSG_WIDTH*i +: MSG_WIDTH];
            up_next_ptr_c = PTR_W'((i + 1) % NUM_CHILDREN);
         end
      end
   end

   // One-entry output register; load and drain may coincide
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         host_up_valid <= 1'b0;
         host_up_data  <= '0;
         rr_ptr        <= '0;
      end else if (up_load_ok_c) begin
         host_up_valid <= |up_grant_c;
         if (|up_grant_c) begin
            host_up_data <= up_sel_data_c;
            rr_ptr       <= up_next_ptr_c;
         end
      end
   end

endmodule

// File: tb/tb_parent_link_router.sv
// Directed self-checking bench for parent_link_router (NUM_CHILDREN = 4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_parent_link_router;

   localparam int unsigned N = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [63:0]     host_down_data;
   logic            host_down_valid;
   logic            host_down_ready;
   logic [63:0]     host_up_data;
   logic            host_up_valid;
   logic            host_up_ready;
   logic [64*N-1:0] child_rx_data;
   logic [N-1:0]    child_rx_valid;
   logic [N-1:0]    child_rx_ready;
   logic [64*N-1:0] child_tx_data;
   logic [N-1:0]    child_tx_valid;
   logic [N-1:0]    child_tx_ready;
   logic [15:0]     drop_count;

   int checks = 0;
   int errors = 0;

   logic [63:0] cdata [N];

   always #5 clk = ~clk;

   parent_link_router #(
      .NUM_CHILDREN   (N),
      .MSG_WIDTH      (64),
      .DROP_CNT_WIDTH (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .host_down_data  (host_down_data),
      .host_down_valid (host_down_valid),
      .host_down_ready (host_down_ready),
      .host_up_data    (host_up_data),
      .host_up_valid   (host_up_valid),
      .host_up_ready   (host_up_ready),
      .child_rx_data   (child_rx_data),
      .child_rx_valid  (child_rx_valid),
      .child_rx_ready  (child_rx_ready),
      .child_tx_data   (child_tx_data),
      .child_tx_valid  (child_tx_valid),
      .child_tx_ready  (child_tx_ready),
      .drop_count      (drop_count)
   );

   always_comb begin
      for (int i = 0; i < N; i++) child_tx_data[64*i +: 64] = cdata[i];
   end

   task automatic test_reset();
      reset           = 1'b1;
      host_down_data  = '0;
      host_down_valid = 1'b0;
      host_up_ready   = 1'b0;
      child_rx_ready  = '0;
      child_tx_valid  = 4'hF;
      for (int i = 0; i < N; i++) cdata[i] = 64'hC0DE_0000_0000_0000 | 64'(i + 1);
      repeat (3) @(negedge clk);
      checks++; if (host_down_ready !== 1'b0) begin errors++; $display("FAIL reset_down_ready: got %b want 0", host_down_ready); end
      checks++; if (host_up_valid !== 1'b0) begin errors++; $display("FAIL reset_up_valid: got %b want 0", host_up_valid); end
      checks++; if (host_up_data !== 64'h0) begin errors++; $display("FAIL reset_up_data: got %h want 0", host_up_data); end
      checks++; if (child_rx_valid !== 4'h0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0000", child_rx_valid); end
      checks++; if (child_rx_data !== '0) begin errors++; $display("FAIL reset_rx_data: got %h want 0", child_rx_data); end
      checks++; if (child_tx_ready !== 4'h0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0000", child_tx_ready); end
      checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
      child_tx_valid = '0;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (host_down_ready !== 1'b1) begin errors++; $display("FAIL post_reset_down_ready: got %b want 1", host_down_ready); end
   endtask

   task automatic test_unicast();
      logic [63:0] msg;
      msg = 64'h1200_0000_0000_0ABC;
      host_down_data  = msg;
      host_down_valid = 1'b1;
      child_rx_ready  = 4'b0000;
      @(negedge clk);
      host_down_valid = 1'b0;
      checks++; if (child_rx_valid !== 4'b0010) begin errors++; $display("FAIL uni_valid: got %b want 0010", child_rx_valid); end
      checks++; if (child_rx_data[64 +: 64] !== msg) begin errors++; $display("FAIL uni_data: got %h want %h", child_rx_data[64 +: 64], msg); end
      checks++; if (host_down_ready !== 1'b0) begin errors++; $display("FAIL uni_busy: got %b want 0", host_down_ready); end
      @(negedge clk);
      checks++; if (child_rx_valid !== 4'b0010) begin errors++; $display("FAIL uni_hold: got %b want 0010", child_rx_valid); end
      child_rx_ready = 4'b0010;
      @(negedge clk);
      checks++; if (child_rx_valid !== 4'b0000) begin errors++; $display("FAIL uni_done_valid: got %b want 0000", child_rx_valid); end
      checks++; if (host_down_ready !== 1'b1) begin errors++; $display("FAIL uni_done_ready: got %b want 1", host_down_ready); end
      child_rx_ready = 4'b0000;
   endtask

   task automatic test_broadcast();
      logic [63:0] msg;
      int cnt [N];
      msg = 64'h3F00_0000_0000_1234;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      host_down_data  = msg;
      host_down_valid = 1'b1;
      child_rx_ready  = 4'b1011;
      @(negedge clk);
      host_down_valid = 1'b0;
      checks++; if (child_rx_valid !== 4'b1111) begin errors++; $display("FAIL bc_valid_all: got %b want 1111", child_rx_valid); end
      checks++; if (child_rx_data[192 +: 64] !== msg) begin errors++; $display("FAIL bc_data3: got %h want %h", child_rx_data[192 +: 64], msg); end
      for (int c = 0; c < 5; c++) begin
         for (int i = 0; i < N; i++) cnt[i] += int'(child_rx_valid[i] & child_rx_ready[i]);
         @(negedge clk);
      end
      checks++; if (child_rx_valid !== 4'b0100) begin errors++; $display("FAIL bc_pending: got %b want 0100", child_rx_valid); end
      checks++; if (host_down_ready !== 1'b0) begin errors++; $display("FAIL bc_still_busy: got %b want 0", host_down_ready); end
      child_rx_ready = 4'b1111;
      for (int i = 0; i < N; i++) cnt[i] += int'(child_rx_valid[i] & child_rx_ready[i]);
      @(negedge clk);
      checks++; if (child_rx_valid !== 4'b0000) begin errors++; $display("FAIL bc_done_valid: got %b want 0000", child_rx_valid); end
      checks++; if (host_down_ready !== 1'b1) begin errors++; $display("FAIL bc_done_ready: got %b want 1", host_down_ready); end
      for (int i = 0; i < N; i++) begin
         checks++; if (cnt[i] != 1) begin errors++; $display("FAIL bc_count child %0d: got %0d want 1", i, cnt[i]); end
      end
      child_rx_ready = 4'b0000;
   endtask

   task automatic test_invalid();
      host_down_data  = 64'h5000_0000_0000_00AA;
      host_down_valid = 1'b1;
      @(negedge clk);
      checks++; if (child_rx_valid !== 4'b0000) begin errors++; $display("FAIL inv0_valid: got %b want 0000", child_rx_valid); end
      checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL inv0_drop: got %0d want 1", drop_count); end
      checks++; if (host_down_ready !== 1'b1) begin errors++; $display("FAIL inv0_ready: got %b want 1", host_down_ready); end
      host_down_data = 64'h5700_0000_0000_00BB;
      @(negedge clk);
      host_down_valid = 1'b0;
      checks++; if (child_rx_valid !== 4'b0000) begin errors++; $display("FAIL inv7_valid: got %b want 0000", child_rx_valid); end
      checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL inv7_drop: got %0d want 2", drop_count); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_rdy;
      child_tx_valid = 4'hF;
      host_up_ready  = 1'b1;
      #1;
      checks++; if (child_tx_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_grant: got %b want 0001", child_tx_ready); end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp_rdy = 4'b0001 << ((k + 1) % 4);
         checks++; if (host_up_valid !== 1'b1) begin errors++; $display("FAIL rr_valid beat %0d: got %b want 1", k, host_up_valid); end
         checks++; if (host_up_data !== cdata[k % 4]) begin errors++; $display("FAIL rr_data beat %0d: got %h want %h", k, host_up_data, cdata[k % 4]); end
         checks++; if (child_tx_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant beat %0d: got %b want %b", k, child_tx_ready, exp_rdy); end
      end
   endtask

   task automatic test_stall();
      for (int c = 0; c < 3; c++) begin
         host_up_ready = 1'b0;
         #1;
         checks++; if (child_tx_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready cyc %0d: got %b want 0000", c, child_tx_ready); end
         @(negedge clk);
         checks++; if (host_up_data !== cdata[3] || host_up_valid !== 1'b1) begin errors++; $display("FAIL stall_hold cyc %0d: got %h/%b want %h/1", c, host_up_data, host_up_valid, cdata[3]); end
      end
      host_up_ready = 1'b1;
      #1;
      checks++; if (child_tx_ready !== 4'b0001) begin errors++; $display("FAIL stall_release_grant: got %b want 0001", child_tx_ready); end
      @(negedge clk);
      checks++; if (host_up_data !== cdata[0]) begin errors++; $display("FAIL stall_next0: got %h want %h", host_up_data, cdata[0]); end
      @(negedge clk);
      checks++; if (host_up_data !== cdata[1]) begin errors++; $display("FAIL stall_next1: got %h want %h", host_up_data, cdata[1]); end
      child_tx_valid = 4'h0;
      @(negedge clk);
      checks++; if (host_up_valid !== 1'b0) begin errors++; $display("FAIL up_empty: got %b want 0", host_up_valid); end
      child_tx_valid = 4'b1001;
      #1;
      checks++; if (child_tx_ready !== 4'b1000) begin errors++; $display("FAIL ptr_kept: got %b want 1000", child_tx_ready); end
      child_tx_valid = 4'h0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_broadcast();
      logic [63:0] msg;
      host_up_ready   = 1'b0;
      host_down_data  = 64'h4F00_0000_0000_5555;
      host_down_valid = 1'b1;
      child_rx_ready  = 4'b0011;
      @(negedge clk);
      host_down_valid = 1'b0;
      @(negedge clk);
      checks++; if (child_rx_valid !== 4'b1100) begin errors++; $display("FAIL mid_partial: got %b want 1100", child_rx_valid); end
      reset = 1'b1;
      #1;
      checks++; if (child_rx_valid !== 4'b0000) begin errors++; $display("FAIL mid_rst_valid: got %b want 0000", child_rx_valid); end
      checks++; if (child_rx_data !== '0) begin errors++; $display("FAIL mid_rst_data: got %h want 0", child_rx_data); end
      checks++; if (host_down_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", host_down_ready); end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL mid_rst_drop: got %0d want 0", drop_count); end
      checks++; if (host_up_valid !== 1'b0 || host_up_data !== 64'h0) begin errors++; $display("FAIL mid_rst_up: got %b/%h want 0/0", host_up_valid, host_up_data); end
      @(negedge clk);
      reset = 1'b0;
      child_rx_ready = 4'b0000;
      @(negedge clk);
      checks++; if (host_down_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_ready: got %b want 1", host_down_ready); end
      msg = 64'h2300_0000_0000_0777;
      host_down_data  = msg;
      host_down_valid = 1'b1;
      @(negedge clk);
      host_down_valid = 1'b0;
      checks++; if (child_rx_valid !== 4'b0100) begin errors++; $display("FAIL mid_uni_valid: got %b want 0100", child_rx_valid); end
      checks++; if (child_rx_data[128 +: 64] !== msg) begin errors++; $display("FAIL mid_uni_data: got %h want %h", child_rx_data[128 +: 64], msg); end
      child_rx_ready = 4'b0100;
      @(negedge clk);
      checks++; if (child_rx_valid !== 4'b0000 || host_down_ready !== 1'b1) begin errors++; $display("FAIL mid_uni_done: got %b/%b want 0000/1", child_rx_valid, host_down_ready); end
      child_rx_ready = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_unicast();
      test_broadcast();
      test_invalid();
      test_round_robin();
      test_stall();
      test_reset_mid_broadcast();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/parent_link_router.md
Name: parent_link_router

Overview:
- Parent-side end of the 64-bit parent_rx/parent_tx link between the root controller and every child FPGA core.
- Downstream: takes single-beat 64-bit control messages from the root controller and delivers each one to one child FPGA, or to all children as a broadcast.
- Upstream: merges the children's 64-bit reports into one stream towards the root controller, using a fair round-robin arbiter.
- Lives in the root/multi-FPGA wrapper, between the root unified controller FIFOs and the per-child links.

Parameters:
- NUM_CHILDREN, 4: number of child FPGAs. Child FPGA IDs are 1..NUM_CHILDREN; ID 0 is the parent.
- MSG_WIDTH, 64: message width. Fixed at 64; other values are unsupported.
- DROP_CNT_WIDTH, 16: width of the dropped-message counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- host_down_data  in  64  message from root controller to children.
- host_down_valid  in  1  host_down_data valid.
- host_down_ready  out  1  router accepts host_down_data.
- host_up_data  out  64  child message forwarded to root controller.
- host_up_valid  out  1  host_up_data valid.
- host_up_ready  in  1  root controller accepts.
- child_rx_data  out  64*NUM_CHILDREN  per-child downstream data; child i (ID i+1) occupies slice [64*i +: 64].
- child_rx_valid  out  NUM_CHILDREN  per-child downstream valid.
- child_rx_ready  in  NUM_CHILDREN  per-child downstream ready.
- child_tx_data  in  64*NUM_CHILDREN  per-child upstream data.
- child_tx_valid  in  NUM_CHILDREN  per-child upstream valid.
- child_tx_ready  out  NUM_CHILDREN  per-child upstream ready.
- drop_count  out  DROP_CNT_WIDTH  count of downstream messages with an invalid destination.

Behaviour:
- Handshakes: valid/ready everywhere; a transfer happens on a clock edge where valid & ready are both 1. Valid never depends on ready. Data is held stable while valid=1 and ready=0.
- Message header: bits [63:60] are the message type (passed through untouched). Bits [59:56] are the destination FPGA ID. Destination 4'hF means broadcast. Bits [55:0] are the payload.
- Reset values:
  - host_down_ready=0, host_up_valid=0, host_up_data=0.
  - child_rx_valid=0, child_rx_data=0, child_tx_ready=0.
  - drop_count=0, arbiter pointer=0.
  - Downstream FSM in IDLE, delivered mask=0.
- Downstream FSM states:
  - IDLE:
    - host_down_ready=1.
    - On accept, latch the message into the hold register and decode its destination.
    - Destination 1..NUM_CHILDREN or F: go to DELIVER next cycle.
    - Any other destination (including 0): drop the message, drop_count+1 (saturating at all-ones), stay in IDLE.
  - DELIVER:
    - host_down_ready=0.
    - Target mask = one-hot (ID-1) for unicast, all ones for broadcast.
    - child_rx_valid = target & ~delivered.
    - All child_rx_data slices carry the hold register.
    - Each cycle, delivered |= child_rx_valid & child_rx_ready.
    - When (delivered | accepted-this-cycle) covers the target mask: clear delivered and go to IDLE.
- Downstream timing:
  - Minimum accept-to-child_rx_valid latency is 1 cycle.
  - Throughput is 1 message per 2 cycles with no backpressure.
  - A broadcast finishes only after every child has accepted it. Children may accept in different cycles, and each child sees the message exactly once.
- Upstream path:
  - One-entry output register.
  - When the register is empty, or is draining this cycle (host_up_valid & host_up_ready), grant the first child with child_tx_valid=1, searching from the pointer upward with wrap-around.
  - child_tx_ready is 1 only for the granted child; that is the cycle the register loads. The pointer moves to granted+1 mod NUM_CHILDREN.
  - No valid children: register empties, host_up_valid=0, pointer unchanged.
  - Timing: latency 1 cycle; sustained throughput 1 message per cycle.
  - Forwarding is transparent: there is no header modification upstream.
- Simultaneous events:
  - The upstream and downstream paths are fully independent and may both transfer in the same cycle.
  - Load and drain of the upstream register in the same cycle is legal and gives no bubble.
- Reset asserted mid-operation: all state clears immediately. A partially delivered broadcast is abandoned, and children are expected to be reset by the same signal.

Decomposition:
- Shared package/include with the parameters: MSG_TYPE_MSB/LSB=63/60, MSG_DEST_MSB/LSB=59/56, BROADCAST_ID=4'hF, plus the downstream state encoding.
- Sub-module rr_arbiter: NUM_CHILDREN request vector, pointer input, one-hot grant output. It is combinational and the pointer register lives in the parent.

Test Plan:
- Unicast: host sends 0x1_2_00000000000ABC with NUM_CHILDREN=4 -> only child_rx_valid[1] asserts, one cycle after accept. Slice 1 equals the message. host_down_ready returns to 1 the cycle after child 1 accepts.
- Broadcast under backpressure: dest=F. Child 2 holds ready=0 for 5 cycles, the others hold ready=1 -> children 0, 1 and 3 each see exactly one transfer. The FSM stays in DELIVER until child 2 accepts, then returns to IDLE.
- Invalid destinations: dest=0, then dest=7 -> no child_rx_valid on either; drop_count increments 0->1->2.
- Upstream round-robin: all 4 children hold valid continuously with distinct data and host_up_ready=1 -> host_up_data order is child 0,1,2,3,0,... at one message per cycle.
- Upstream stall: host_up_ready=0 for 3 cycles -> host_up_data is stable and all child_tx_ready=0. On release there are no duplicated or lost messages.
- Reset mid-broadcast: assert reset while delivered=4'b0011 -> all outputs reach their reset values immediately. After release, a new unicast to child 3 delivers normally.
